// File: rtl/signal_delay_meter.sv
// Round-trip latency meter: launches a one-cycle pulse, counts cycles to the
// first rising edge on rx_signal, and keeps min/max statistics.
module signal_delay_meter #(
    parameter  int MAX_CYCLES = 255,
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             rx_signal,
    output logic             tx_pulse,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] delay_cycles,
    output logic [CNT_W-1:0] delay_min,
    output logic [CNT_W-1:0] delay_max,
    output logic             stats_valid
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MEASURE = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES);

    logic [0:0]       state;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic             rx_edge;

    assign rx_edge = rx_signal & ~rx_prev;
    assign busy    = (state == MEASURE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rx_prev      <= 1'b0;
            cnt          <= '0;
            tx_pulse     <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            delay_cycles <= '0;
            delay_min    <= '1;
            delay_max    <= '0;
            stats_valid  <= 1'b0;
        end else begin
            rx_prev <= rx_signal;
            done    <= 1'b0;

            // A stats update later in this block overrides a coincident clear.
            if (clear) begin
                delay_min   <= '1;
                delay_max   <= '0;
                stats_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= MEASURE;
                        tx_pulse <= 1'b1;
                        cnt      <= '0;
                    end
                end
                MEASURE: begin
                    tx_pulse <= 1'b0;
                    if (rx_edge) begin
                        delay_cycles <= cnt;
                        timeout      <= 1'b0;
                        done         <= 1'b1;
                        state        <= IDLE;
                        delay_min    <= (clear || cnt < delay_min) ? cnt : delay_min;
                        delay_max    <= (clear || cnt > delay_max) ? cnt : delay_max;
                        stats_valid  <= 1'b1;
                    end else if (cnt == CNT_MAX) begin
                        delay_cycles <= CNT_MAX;
                        timeout      <= 1'b1;
                        done         <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_signal_delay_meter.sv
// Bench for signal_delay_meter: two instances (MAX_CYCLES 255 and 15) driven
// through bench-side register paths; results checked against an expected queue.
module tb_signal_delay_meter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // instance a: MAX_CYCLES = 255
    logic       start_a, clear_a, rx_a, tx_a, busy_a, done_a, to_a, valid_a;
    logic [7:0] delay_a, min_a, max_a;
    // instance b: MAX_CYCLES = 15
    logic       start_b, clear_b, rx_b, tx_b, busy_b, done_b, to_b, valid_b;
    logic [3:0] delay_b, min_b, max_b;

    signal_delay_meter dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .clear(clear_a), .rx_signal(rx_a),
        .tx_pulse(tx_a), .busy(busy_a), .done(done_a), .timeout(to_a),
        .delay_cycles(delay_a), .delay_min(min_a), .delay_max(max_a), .stats_valid(valid_a)
    );

    signal_delay_meter #(.MAX_CYCLES(15)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .clear(clear_b), .rx_signal(rx_b),
        .tx_pulse(tx_b), .busy(busy_b), .done(done_b), .timeout(to_b),
        .delay_cycles(delay_b), .delay_min(min_b), .delay_max(max_b), .stats_valid(valid_b)
    );

    // Paths under test: mode 0 = N-register path (0 = wire), 1 = tied low, 2 = tied high.
    int path_a = 0, mode_a = 1, path_b = 0, mode_b = 1;
    logic flush_a = 1'b0;
    logic [31:0] sr_a = '0, sr_b = '0;

    always @(posedge clk) begin
        sr_a <= flush_a ? 32'd0 : {sr_a[30:0], tx_a};
        sr_b <= {sr_b[30:0], tx_b};
    end

    always_comb begin
        rx_a = 1'b0;
        if (mode_a == 2) rx_a = 1'b1;
        else if (mode_a == 0) rx_a = (path_a == 0) ? tx_a : sr_a[path_a-1];
        rx_b = 1'b0;
        if (mode_b == 2) rx_b = 1'b1;
        else if (mode_b == 0) rx_b = (path_b == 0) ? tx_b : sr_b[path_b-1];
    end

    // Expected entry: [41:26] done cycle, [25] valid, [24:17] max, [16:9] min, [8] timeout, [7:0] delay
    logic [41:0] exp_a_q[$];
    logic [41:0] exp_b_q[$];

    function automatic logic [41:0] pk(int c, logic v, logic [7:0] mx, logic [7:0] mn,
                                       logic t, logic [7:0] d);
        logic [15:0] c16;
        c16 = c[15:0];
        return {c16, v, mx, mn, t, d};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        logic [41:0] e;
        if (rst_n && done_a) begin
            if (exp_a_q.size() == 0) fail_now("a_unexpected_done");
            else begin
                e = exp_a_q.pop_front();
                chk("a_done_cycle", 32'(cyc[15:0]), 32'(e[41:26]));
                chk("a_delay", delay_a, e[7:0]);
                chk("a_timeout", to_a, e[8]);
                chk("a_min", min_a, e[16:9]);
                chk("a_max", max_a, e[24:17]);
                chk("a_valid", valid_a, e[25]);
            end
        end
        if (rst_n && done_b) begin
            if (exp_b_q.size() == 0) fail_now("b_unexpected_done");
            else begin
                e = exp_b_q.pop_front();
                chk("b_done_cycle", 32'(cyc[15:0]), 32'(e[41:26]));
                chk("b_delay", delay_b, e[7:0]);
                chk("b_timeout", to_b, e[8]);
                chk("b_min", min_b, e[16:9]);
                chk("b_max", max_b, e[24:17]);
                chk("b_valid", valid_b, e[25]);
            end
        end
    end

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done_a();
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_a) begin ok = 1; break; end
        end
        if (!ok) fail_now("a_done_wait_expired");
    endtask

    task automatic wait_done_b();
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_b) begin ok = 1; break; end
        end
        if (!ok) fail_now("b_done_wait_expired");
    endtask

    task automatic chk_reset_a();
        chk("a_rst_tx", tx_a, 0);      chk("a_rst_busy", busy_a, 0);
        chk("a_rst_done", done_a, 0);  chk("a_rst_timeout", to_a, 0);
        chk("a_rst_delay", delay_a, 0); chk("a_rst_min", min_a, 8'hFF);
        chk("a_rst_max", max_a, 0);    chk("a_rst_valid", valid_a, 0);
    endtask

    task automatic chk_reset_b();
        chk("b_rst_tx", tx_b, 0);      chk("b_rst_busy", busy_b, 0);
        chk("b_rst_done", done_b, 0);  chk("b_rst_timeout", to_b, 0);
        chk("b_rst_delay", delay_b, 0); chk("b_rst_min", min_b, 4'hF);
        chk("b_rst_max", max_b, 0);    chk("b_rst_valid", valid_b, 0);
    endtask

    initial begin
        int c;
        int ntx;
        rst_n = 1'b0;
        start_a = 0; clear_a = 0; start_b = 0; clear_b = 0;
        wait_cyc(3);
        chk_reset_a();
        chk_reset_b();
        rst_n = 1'b1;

        // reset in the middle of a measurement
        mode_a = 1;
        wait_cyc(2);
        start_a = 1;
        @(negedge clk) start_a = 0;
        wait_cyc(4);
        chk("a_busy_before_abort", busy_a, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_a();
        @(negedge clk) rst_n = 1'b1;

        // 5-register loopback, single start
        mode_a = 0; path_a = 5;
        wait_cyc(40);
        start_a = 1;
        exp_a_q.push_back(pk(cyc + 7, 1, 5, 5, 0, 5));
        @(negedge clk) start_a = 0;
        chk("a_tx_in_t0", tx_a, 1);
        @(negedge clk) chk("a_tx_in_t1", tx_a, 0);
        wait_done_a();

        // clear alone
        @(negedge clk) clear_a = 1;
        @(negedge clk) clear_a = 0;
        chk("a_clear_valid", valid_a, 0);
        chk("a_clear_min", min_a, 8'hFF);
        chk("a_clear_max", max_a, 0);
        chk("a_clear_delay_held", delay_a, 5);

        // back-to-back: 3, 7, 2 registers, each start issued in the done cycle
        path_a = 3;
        wait_cyc(40);
        start_a = 1;
        exp_a_q.push_back(pk(cyc + 5, 1, 3, 3, 0, 3));
        @(negedge clk) start_a = 0;
        wait_done_a();
        path_a = 7; flush_a = 1; start_a = 1;
        exp_a_q.push_back(pk(cyc + 9, 1, 7, 3, 0, 7));
        @(negedge clk) begin start_a = 0; flush_a = 0; end
        wait_done_a();
        path_a = 2; flush_a = 1; start_a = 1;
        exp_a_q.push_back(pk(cyc + 4, 1, 7, 2, 0, 2));
        @(negedge clk) begin start_a = 0; flush_a = 0; end
        wait_done_a();

        // start held for 10 cycles over a 5-register measurement
        path_a = 5;
        wait_cyc(40);
        start_a = 1;
        c = cyc;
        exp_a_q.push_back(pk(c + 7, 1, 7, 2, 0, 5));
        exp_a_q.push_back(pk(c + 14, 1, 7, 2, 0, 5));
        ntx = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (tx_a) ntx++;
            if (i == 10) start_a = 0;
            if (i == 7) chk("a_tx_count_first_busy", ntx, 1);
        end
        chk("a_tx_count_total", ntx, 2);

        // clear coincident with a result of 4
        path_a = 4;
        wait_cyc(40);
        start_a = 1;
        exp_a_q.push_back(pk(cyc + 6, 1, 4, 4, 0, 4));
        @(negedge clk) start_a = 0;
        wait_cyc(4);
        clear_a = 1;
        @(negedge clk) clear_a = 0;

        // combinational loopback
        path_a = 0;
        wait_cyc(40);
        start_a = 1;
        exp_a_q.push_back(pk(cyc + 2, 1, 4, 0, 0, 0));
        @(negedge clk) start_a = 0;
        wait_done_a();

        // instance b: rx tied low, then tied high -> timeout at 15
        mode_b = 1;
        wait_cyc(5);
        start_b = 1;
        exp_b_q.push_back(pk(cyc + 17, 0, 0, 8'h0F, 1, 15));
        @(negedge clk) start_b = 0;
        wait_done_b();
        mode_b = 2;
        wait_cyc(5);
        start_b = 1;
        exp_b_q.push_back(pk(cyc + 17, 0, 0, 8'h0F, 1, 15));
        @(negedge clk) start_b = 0;
        wait_done_b();

        // edge exactly at cnt = MAX_CYCLES beats the timeout
        mode_b = 0; path_b = 15;
        wait_cyc(40);
        start_b = 1;
        exp_b_q.push_back(pk(cyc + 17, 1, 15, 15, 0, 15));
        @(negedge clk) start_b = 0;
        wait_done_b();

        wait_cyc(5);
        chk("a_queue_drained", exp_a_q.size(), 0);
        chk("b_queue_drained", exp_b_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
